// File: rtl/lock_confidence_monitor.sv
// Lock confidence monitor: hysteretic UNLOCKED/ACQUIRING/LOCKED/LOSING tracker with dwell counting.
// Optional lock-loss statistic enabled by defining LOCK_MONITOR_STATS_EN.
package common_p;
  typedef struct packed {
    logic clk;
    logic rst;
  } clk_dom_s;
endpackage

module lock_confidence_monitor #(
  parameter int unsigned BIT_WIDTH   = 8,
  parameter int unsigned DWELL_WIDTH = 8,
  parameter int unsigned STAT_WIDTH  = 16
) (
  input  common_p::clk_dom_s       sys_dom_i,
  input  logic [BIT_WIDTH-1:0]     count_i,
  input  logic                     count_valid_i,
  input  logic [BIT_WIDTH-1:0]     lock_threshold_i,
  input  logic [BIT_WIDTH-1:0]     unlock_threshold_i,
  input  logic [DWELL_WIDTH-1:0]   lock_dwell_i,
  input  logic [DWELL_WIDTH-1:0]   unlock_dwell_i,
  input  logic                     force_unlock_i,
  output logic                     locked_o,
  output logic                     lock_event_o,
  output logic                     unlock_event_o,
  output logic [1:0]               state_o,
  output logic [STAT_WIDTH-1:0]    lock_loss_count_o
);

  localparam logic [1:0] ST_UNLOCKED  = 2'd0;
  localparam logic [1:0] ST_ACQUIRING = 2'd1;
  localparam logic [1:0] ST_LOCKED    = 2'd2;
  localparam logic [1:0] ST_LOSING    = 2'd3;

  logic                   clk;
  logic                   rst;
  logic [1:0]             state_q, state_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [DWELL_WIDTH-1:0] dwell_inc;
  logic                   lock_ev_q, lock_ev_d;
  logic                   unlock_ev_q, unlock_ev_d;
  logic                   locked_q;
  logic                   acq_qual;
  logic                   loss_qual;

  assign clk = sys_dom_i.clk;
  assign rst = sys_dom_i.rst;

  assign acq_qual  = count_valid_i && (count_i >= lock_threshold_i);
  assign loss_qual = count_valid_i && (count_i < unlock_threshold_i);
  assign dwell_inc = (dwell_q == '1) ? dwell_q : dwell_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    lock_ev_d   = 1'b0;
    unlock_ev_d = 1'b0;
    if (force_unlock_i) begin
      state_d     = ST_UNLOCKED;
      dwell_d     = '0;
      unlock_ev_d = (state_q == ST_LOCKED) || (state_q == ST_LOSING);
    end else if (count_valid_i) begin
      unique case (state_q)
        ST_UNLOCKED: begin
          if (acq_qual) begin
            if (lock_dwell_i <= DWELL_WIDTH'(1)) begin
              state_d   = ST_LOCKED;
              dwell_d   = '0;
              lock_ev_d = 1'b1;
            end else begin
              state_d = ST_ACQUIRING;
              dwell_d = DWELL_WIDTH'(1);
            end
          end
        end
        ST_ACQUIRING: begin
          if (acq_qual) begin
            if (dwell_inc >= lock_dwell_i) begin
              state_d   = ST_LOCKED;
              dwell_d   = '0;
              lock_ev_d = 1'b1;
            end else begin
              dwell_d = dwell_inc;
            end
          end else begin
            state_d = ST_UNLOCKED;
            dwell_d = '0;
          end
        end
        ST_LOCKED: begin
          if (loss_qual) begin
            if (unlock_dwell_i <= DWELL_WIDTH'(1)) begin
              state_d     = ST_UNLOCKED;
              dwell_d     = '0;
              unlock_ev_d = 1'b1;
            end else begin
              state_d = ST_LOSING;
              dwell_d = DWELL_WIDTH'(1);
            end
          end
        end
        default: begin
          if (loss_qual) begin
            if (dwell_inc >= unlock_dwell_i) begin
              state_d     = ST_UNLOCKED;
              dwell_d     = '0;
              unlock_ev_d = 1'b1;
            end else begin
              dwell_d = dwell_inc;
            end
          end else begin
            state_d = ST_LOCKED;
            dwell_d = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_UNLOCKED;
      dwell_q     <= '0;
      lock_ev_q   <= 1'b0;
      unlock_ev_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      lock_ev_q   <= lock_ev_d;
      unlock_ev_q <= unlock_ev_d;
      locked_q    <= state_d[1];
    end
  end

  assign state_o        = state_q;
  assign locked_o       = locked_q;
  assign lock_event_o   = lock_ev_q;
  assign unlock_event_o = unlock_ev_q;

`ifdef LOCK_MONITOR_STATS_EN
  logic [STAT_WIDTH-1:0] stat_q;

  // Counted off the next-cycle event so the statistic steps in the same cycle as the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= '0;
    end else if (unlock_ev_d && (stat_q != '1)) begin
      stat_q <= stat_q + 1'b1;
    end
  end

  assign lock_loss_count_o = stat_q;
`else
  assign lock_loss_count_o = '0;
`endif

endmodule

// File: tb/tb_lock_confidence_monitor.sv
// Scoreboard bench for lock_confidence_monitor: directed samples push expected outputs, a monitor pops and compares.
module tb_lock_confidence_monitor;

  typedef struct packed {
    logic [1:0] st;
    logic       lev;
    logic       uev;
    logic [1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  common_p::clk_dom_s sys_dom;
  logic [7:0] count     = '0;
  logic       valid     = 1'b0;
  logic [7:0] lock_thr  = 8'd10;
  logic [7:0] unl_thr   = 8'd4;
  logic [7:0] lock_dw   = 8'd3;
  logic [7:0] unl_dw    = 8'd2;
  logic       force_unl = 1'b0;
  logic       locked;
  logic       lock_ev;
  logic       unlock_ev;
  logic [1:0] state;
  logic [1:0] loss_cnt;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_loss = 0;
  bit   done   = 1'b0;

  assign sys_dom.clk = clk;
  assign sys_dom.rst = rst;

  always #5 clk = ~clk;

  lock_confidence_monitor #(
    .BIT_WIDTH  (8),
    .DWELL_WIDTH(8),
    .STAT_WIDTH (2)
  ) dut (
    .sys_dom_i         (sys_dom),
    .count_i           (count),
    .count_valid_i     (valid),
    .lock_threshold_i  (lock_thr),
    .unlock_threshold_i(unl_thr),
    .lock_dwell_i      (lock_dw),
    .unlock_dwell_i    (unl_dw),
    .force_unlock_i    (force_unl),
    .locked_o          (locked),
    .lock_event_o      (lock_ev),
    .unlock_event_o    (unlock_ev),
    .state_o           (state),
    .lock_loss_count_o (loss_cnt)
  );

  function automatic logic [1:0] exp_cnt(input int n);
`ifdef LOCK_MONITOR_STATS_EN
    return (n > 3) ? 2'd3 : 2'(n);
`else
    return 2'd0;
`endif
  endfunction

  // Drive one cycle of stimulus and queue the response expected on the following cycle.
  task automatic step(input logic r, input logic v, input logic f, input logic [7:0] c,
                      input logic [1:0] est, input logic elev, input logic euev);
    exp_t e;
    @(negedge clk);
    rst       = r;
    valid     = v;
    force_unl = f;
    count     = c;
    if (r) n_loss = 0;
    else if (euev) n_loss++;
    e.st  = est;
    e.lev = elev;
    e.uev = euev;
    e.cnt = exp_cnt(n_loss);
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (state !== e.st || locked !== e.st[1] || lock_ev !== e.lev ||
          unlock_ev !== e.uev || loss_cnt !== e.cnt) begin
        errors++;
        $display("FAIL outputs t=%0t: state=%0d locked=%0b lev=%0b uev=%0b cnt=%0d, required state=%0d locked=%0b lev=%0b uev=%0b cnt=%0d",
                 $time, state, locked, lock_ev, unlock_ev, loss_cnt,
                 e.st, e.st[1], e.lev, e.uev, e.cnt);
      end
      checks++;
      if (lock_ev && unlock_ev) begin
        errors++;
        $display("FAIL event_exclusive t=%0t: lev=%0b uev=%0b, required not both 1", $time, lock_ev, unlock_ev);
      end
    end
  end

  initial begin
    // Reset
    step(1, 0, 0, 8'd0,   2'd0, 0, 0);
    step(1, 0, 0, 8'd0,   2'd0, 0, 0);
    // Acquire: 12, 15, 11 with lock_thr 10, dwell 3
    step(0, 1, 0, 8'd12,  2'd1, 0, 0);
    step(0, 1, 0, 8'd15,  2'd1, 0, 0);
    step(0, 1, 0, 8'd11,  2'd2, 1, 0);
    step(0, 0, 0, 8'd0,   2'd2, 0, 0);
    // Loss with hysteresis: 3, 5, 3, 2 with unlock_thr 4, dwell 2
    step(0, 1, 0, 8'd3,   2'd3, 0, 0);
    step(0, 1, 0, 8'd5,   2'd2, 0, 0);
    step(0, 1, 0, 8'd3,   2'd3, 0, 0);
    step(0, 1, 0, 8'd2,   2'd0, 0, 1);
    // Acquire abort with a gap: 12, invalid, 12, 9
    step(0, 1, 0, 8'd12,  2'd1, 0, 0);
    step(0, 0, 0, 8'd12,  2'd1, 0, 0);
    step(0, 1, 0, 8'd12,  2'd1, 0, 0);
    step(0, 1, 0, 8'd9,   2'd0, 0, 0);
    // Force during ACQUIRING gives no event
    step(0, 1, 0, 8'd12,  2'd1, 0, 0);
    step(0, 1, 1, 8'd12,  2'd0, 0, 0);
    // Zero dwell and force
    @(negedge clk); lock_thr = 8'd100; lock_dw = 8'd0;
    step(0, 1, 0, 8'd200, 2'd2, 1, 0);
    step(0, 1, 1, 8'd200, 2'd0, 0, 1);
    step(0, 0, 1, 8'd0,   2'd0, 0, 0);
    // Unit dwells: direct lock/unlock, repeated to saturate the statistic
    @(negedge clk); lock_thr = 8'd10; lock_dw = 8'd1; unl_thr = 8'd4; unl_dw = 8'd1;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 8'd50, 2'd2, 1, 0);
      step(0, 1, 0, 8'd3,  2'd0, 0, 1);
    end
    // Reset while LOCKED: no unlock pulse, statistic cleared
    step(0, 1, 0, 8'd50,  2'd2, 1, 0);
    step(1, 1, 0, 8'd3,   2'd0, 0, 0);
    step(0, 0, 0, 8'd3,   2'd0, 0, 0);
    // Inverted thresholds followed literally
    @(negedge clk); unl_thr = 8'd20;
    step(0, 1, 0, 8'd15,  2'd2, 1, 0);
    step(0, 1, 0, 8'd15,  2'd0, 0, 1);
    step(0, 0, 0, 8'd15,  2'd0, 0, 0);
    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
